// File: rtl/repadd_feeder.sv
// -----------------------------------------------------------------------------
// repadd_feeder
//   Sequences one operand pair into a repeated-addition multiplier over a
//   shared operand bus, waits for the multiplier's done level (or a cycle
//   timeout), presents the result downstream with a valid/ready handshake and
//   then clears the multiplier with a one-cycle pulse.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake for the operand pair
//   in_a, in_b           multiplicand, multiplier (repeat count)
//   start                one-cycle start strobe to the multiplier control
//   din                  shared operand bus (A for two cycles, then B)
//   done, prod           multiplier finished level and product register
//   mul_rst              one-cycle multiplier clear, active high
//   out_valid/out_ready  downstream handshake for the result
//   out_prod, out_err    captured product, timeout flag
//
// All outputs come straight from flops, so none of in_valid, done or
// out_ready has a combinational path to an output.
// -----------------------------------------------------------------------------
module repadd_feeder #(
  parameter int unsigned W   = 16,
  parameter int unsigned TMO = 70000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         start,
  output logic [W-1:0] din,
  input  logic         done,
  input  logic [W-1:0] prod,
  output logic         mul_rst,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LDA   = 3'd2,
    S_LDB   = 3'd3,
    S_RUN   = 3'd4,
    S_OUT   = 3'd5,
    S_CLR   = 3'd6
  } state_t;

  localparam logic [16:0] LP_CNT_LAST = 17'(TMO - 1);

  state_t      r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [16:0] r_cnt;
  logic        r_in_ready;
  logic        r_start;
  logic [W-1:0] r_din;
  logic        r_mul_rst;
  logic        r_out_valid;
  logic [W-1:0] r_out_prod;
  logic        r_out_err;

  // Outputs are registered alongside the state transition so each one
  // already holds the value belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_start     <= 1'b0;
      r_din       <= '0;
      r_mul_rst   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is low during the first cycle after reset release, so
          // acceptance is qualified by it to keep the handshake honest.
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_in_ready <= 1'b0;
            r_start    <= 1'b1;
            r_din      <= in_a;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_start <= 1'b0;
          r_din   <= r_a;
          r_state <= S_LDA;
        end
        S_LDA: begin
          r_din   <= r_b;
          r_state <= S_LDB;
        end
        S_LDB: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 17'd1;
          // done is tested first so it wins over a coincident timeout.
          if (done) begin
            r_out_prod  <= prod;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_din       <= '0;
            r_state     <= S_OUT;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_out_prod  <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_din       <= '0;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_mul_rst   <= 1'b1;
            r_state     <= S_CLR;
          end
        end
        S_CLR: begin
          r_mul_rst  <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_start     <= 1'b0;
          r_din       <= '0;
          r_mul_rst   <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign start     = r_start;
  assign din       = r_din;
  assign mul_rst   = r_mul_rst;
  assign out_valid = r_out_valid;
  assign out_prod  = r_out_prod;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_repadd_feeder.sv
module tb_repadd_feeder;

  localparam int unsigned W   = 16;
  localparam int unsigned TMO = 20;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         start;
  logic [W-1:0] din;
  logic         done;
  logic [W-1:0] prod;
  logic         mul_rst;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic         out_err;

  int n_checks = 0;
  int n_fail   = 0;

  // 0: behavioural multiplier, 1: done tied low, 2: done/prod driven directly
  logic [1:0]   mode;
  logic         t_done;

  // Behavioural repeated-add multiplier following start / din / mul_rst.
  logic [1:0]   m_st;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_p;
  logic         m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 2'd0; m_a <= '0; m_b <= '0; m_p <= '0; m_done <= 1'b0;
    end else if (mul_rst) begin
      m_st <= 2'd0; m_p <= '0; m_done <= 1'b0;
    end else begin
      case (m_st)
        2'd0: if (start) m_st <= 2'd1;
        2'd1: begin m_a <= din; m_st <= 2'd2; end
        2'd2: begin m_b <= din; m_p <= '0; m_st <= 2'd3; end
        default: begin
          if (m_b == '0) m_done <= 1'b1;
          else begin m_p <= m_p + m_a; m_b <= m_b - 1'b1; end
        end
      endcase
    end
  end

  assign done = (mode == 2'd0) ? m_done : (mode == 2'd2) ? t_done : 1'b0;
  assign prod = (mode == 2'd2) ? 16'hBEEF : m_p;

  repadd_feeder #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .din(din), .done(done), .prod(prod), .mul_rst(mul_rst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_accept(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    chk("clr_mul_rst", {31'd0, mul_rst}, 32'd1);
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    tick();
    chk("idle_mul_rst", {31'd0, mul_rst}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_din", {16'd0, din}, 32'd0);
  endtask

  initial begin
    int n;
    logic bad;
    logic seen_v;
    logic seen_m;
    mode = 2'd0; t_done = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_din", {16'd0, din}, 32'd0);
    chk("rst_mul_rst", {31'd0, mul_rst}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_prod", {16'd0, out_prod}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    #3 rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // nominal 7*5
    op_accept(16'd7, 16'd5);
    chk("nom_start", {31'd0, start}, 32'd1);
    chk("nom_din_start", {16'd0, din}, 32'd7);
    chk("nom_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("nom_start_lda", {31'd0, start}, 32'd0);
    chk("nom_din_lda", {16'd0, din}, 32'd7);
    tick();
    chk("nom_din_ldb", {16'd0, din}, 32'd5);
    tick();
    chk("nom_din_run", {16'd0, din}, 32'd5);
    n = 0; bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (din !== 16'd5 || start !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    chk("nom_din_hold", {31'd0, bad}, 32'd0);
    chk("nom_run_cycles", n, 32'd7);
    chk("nom_out_valid", {31'd0, out_valid}, 32'd1);
    chk("nom_out_prod", {16'd0, out_prod}, 32'd35);
    chk("nom_out_err", {31'd0, out_err}, 32'd0);
    chk("nom_din_out", {16'd0, din}, 32'd0);
    chk("nom_mul_rst_out", {31'd0, mul_rst}, 32'd0);
    finish_op();

    // backpressure 6*3
    op_accept(16'd6, 16'd3);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_prod", {16'd0, out_prod}, 32'd18);
      chk("bp_err", {31'd0, out_err}, 32'd0);
      chk("bp_mul_rst", {31'd0, mul_rst}, 32'd0);
    end
    finish_op();

    // timeout: done tied low
    mode = 2'd1;
    op_accept(16'd9, 16'd9);
    wait_valid(n);
    chk("tmo_cycles", n, 32'd23);
    chk("tmo_err", {31'd0, out_err}, 32'd1);
    chk("tmo_prod", {16'd0, out_prod}, 32'd0);
    finish_op();

    // done in IDLE ignored, then tie of done and last counter value
    mode = 2'd2;
    t_done = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_done_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_done_start", {31'd0, start}, 32'd0);
    end
    t_done = 1'b0;
    op_accept(16'd1, 16'd1);
    repeat (22) tick();
    chk("tie_pre_valid", {31'd0, out_valid}, 32'd0);
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    chk("tie_valid", {31'd0, out_valid}, 32'd1);
    chk("tie_prod", {16'd0, out_prod}, 32'h0000BEEF);
    chk("tie_err", {31'd0, out_err}, 32'd0);
    finish_op();

    // reset mid-RUN
    mode = 2'd0;
    op_accept(16'd7, 16'd5);
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_din", {16'd0, din}, 32'd0);
    chk("mid_rst_start", {31'd0, start}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_mul_rst", {31'd0, mul_rst}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    #2 rst_n = 1'b1;
    seen_v = 1'b0; seen_m = 1'b0;
    repeat (30) begin
      tick();
      seen_v |= out_valid;
      seen_m |= mul_rst;
    end
    chk("post_rst_no_valid", {31'd0, seen_v}, 32'd0);
    chk("post_rst_no_mul_rst", {31'd0, seen_m}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    op_accept(16'd3, 16'd4);
    wait_valid(n);
    chk("post_rst_prod", {16'd0, out_prod}, 32'd12);
    chk("post_rst_err", {31'd0, out_err}, 32'd0);
    finish_op();

    // back-to-back with in_valid held high
    in_valid = 1'b1; in_a = 16'd2; in_b = 16'd3;
    tick();
    in_a = 16'd65535; in_b = 16'd1;
    n = 0; bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    chk("b2b_ready_low", {31'd0, bad}, 32'd0);
    chk("b2b_prod1", {16'd0, out_prod}, 32'd6);
    out_ready = 1'b1;
    tick();
    chk("b2b_clr_mul_rst", {31'd0, mul_rst}, 32'd1);
    chk("b2b_clr_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b0;
    tick();
    chk("b2b_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b_idle_start", {31'd0, start}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_start2", {31'd0, start}, 32'd1);
    chk("b2b_din2", {16'd0, din}, 32'd65535);
    wait_valid(n);
    chk("b2b_prod2", {16'd0, out_prod}, 32'd65535);
    chk("b2b_err2", {31'd0, out_err}, 32'd0);
    finish_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
